// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - sequences operand pairs through a start/finish multiplier and accumulates a saturated dot product
module dot_product_sequencer #(
  parameter int WIDTH        = 16,
  parameter int START_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_start,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_overflow,
  input  logic             mul_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, OUT} state_t;

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_t           state, next_state;
  logic [SC_W-1:0]  start_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] prod;
  logic             prod_ovf;
  logic             sticky;
  logic             last;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   sum_ext;
  logic             sum_sat;
  logic [WIDTH-1:0] sum_clamped;

  // One guard bit: differing top two bits means the signed sum left the WIDTH range.
  always_comb begin
    sum_ext     = {acc[WIDTH-1], acc} + {prod[WIDTH-1], prod};
    sum_sat     = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    sum_clamped = sum_ext[WIDTH-1:0];
    if (sum_sat) begin
      sum_clamped = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mul_start  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) next_state = ISSUE;
      end
      ISSUE: begin
        mul_start = 1'b1;
        if (start_cnt == '0) next_state = WAIT;
      end
      WAIT: begin
        if (mul_finish) next_state = ACC;
      end
      ACC: begin
        next_state = last ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_cnt <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      prod      <= '0;
      prod_ovf  <= 1'b0;
      sticky    <= 1'b0;
      last      <= 1'b0;
      count     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last      <= in_last;
            start_cnt <= SC_W'(START_CYCLES - 1);
          end
        end
        ISSUE: begin
          if (start_cnt != '0) start_cnt <= start_cnt - SC_W'(1);
        end
        WAIT: begin
          if (mul_finish) begin
            prod     <= mul_result;
            prod_ovf <= mul_overflow;
          end
        end
        ACC: begin
          acc    <= sum_clamped;
          sticky <= sticky | sum_sat | prod_ovf;
          count  <= count + CNT_W'(1);
        end
        OUT: begin
          if (out_ready) begin
            acc    <= '0;
            sticky <= 1'b0;
            count  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum      = acc;
  assign out_overflow = sticky;
  assign out_count    = count;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - randomized self-checking bench with a Q8.8 multiplier stub and reference model
module tb_dot_product_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic [15:0] mul_a, mul_b;
  logic        mul_start;
  logic [15:0] mul_result = '0;
  logic        mul_overflow = 1'b0;
  logic        mul_finish = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_overflow;
  logic [7:0]  out_count;

  int checks = 0;
  int passed = 0;
  int start_hi;
  logic        force_ovf = 1'b0;
  logic        stub_prev = 1'b0;
  int          stub_cnt = 0;
  logic [15:0] va[$];
  logic [15:0] vb[$];
  logic        vf[$];

  always #5 clk = ~clk;

  dot_product_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_finish(mul_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .out_count(out_count)
  );

  // Q8.8 signed multiply with clamp; returns {overflow, product}
  function automatic logic [16:0] mul_model(input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = (pa * pb) >>> 8;
    if (p > 32767)  return {1'b1, 16'h7FFF};
    if (p < -32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  // Multiplier stub: finish 3 cycles after start falls, cleared when start rises
  always @(posedge clk) begin
    if (rst) begin
      mul_finish <= 1'b0;
      stub_prev  <= 1'b0;
      stub_cnt   <= 0;
    end else begin
      stub_prev <= mul_start;
      if (mul_start) begin
        mul_finish <= 1'b0;
        stub_cnt   <= 0;
      end else if (stub_prev) begin
        stub_cnt <= 3;
      end else if (stub_cnt == 1) begin
        stub_cnt   <= 0;
        mul_finish <= 1'b1;
        {mul_overflow, mul_result} <= mul_model(mul_a, mul_b) | {force_ovf, 16'h0000};
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic model_expect(output logic [15:0] s, output logic o, output logic [7:0] c);
    int acc;
    logic [16:0] r;
    acc = 0; o = 1'b0; c = 8'd0;
    foreach (va[i]) begin
      r = mul_model(va[i], vb[i]);
      o = o | r[16] | vf[i];
      acc = acc + int'($signed(r[15:0]));
      if (acc > 32767)  begin acc = 32767;  o = 1'b1; end
      if (acc < -32768) begin acc = -32768; o = 1'b1; end
      c = c + 8'd1;
    end
    s = acc[15:0];
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic l,
                           input logic f, output bit ok);
    int t;
    t = 0; ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l; force_ovf = f;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (in_ready) begin @(posedge clk); ok = 1; #1; end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_vector(input int gap_max, output bit ok);
    bit pok;
    ok = 1;
    foreach (va[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      push_pair(va[i], vb[i], i == va.size() - 1, vf[i], pok);
      if (!pok) ok = 0;
    end
  endtask

  task automatic wait_result(output bit ok);
    int t;
    t = 0; start_hi = 0;
    @(negedge clk);
    while (!out_valid && t < 500) begin
      if (mul_start) start_hi++;
      @(negedge clk); t++;
    end
    ok = out_valid;
  endtask

  task automatic accept_result(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic set_vec(input logic [15:0] a0, input logic [15:0] b0, input logic f0);
    va.push_back(a0); vb.push_back(b0); vf.push_back(f0);
  endtask

  task automatic check_vector(input string name, input int hold);
    logic [15:0] es; logic eo; logic [7:0] ec; bit ok, rok;
    model_expect(es, eo, ec);
    run_vector(2, ok);
    wait_result(rok);
    checks++; if ((ok && rok) !== 1'b1) $display("FAIL %s handshake: push_ok=%0d result_ok=%0d required 1/1", name, ok, rok); else passed++;
    checks++; if (out_sum !== es) $display("FAIL %s sum: got %h required %h", name, out_sum, es); else passed++;
    checks++; if (out_overflow !== eo) $display("FAIL %s ovf: got %b required %b", name, out_overflow, eo); else passed++;
    checks++; if (out_count !== ec) $display("FAIL %s count: got %0d required %0d", name, out_count, ec); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL %s in_ready_busy: got %b required 0", name, in_ready); else passed++;
    accept_result(hold);
    checks++; if (out_valid !== 1'b0) $display("FAIL %s out_valid_after_accept: got %b required 0", name, out_valid); else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b required 0", in_ready); else passed++;
    checks++; if ({mul_start, out_valid, out_overflow} !== 3'b000) $display("FAIL reset flags: got %b required 000", {mul_start, out_valid, out_overflow}); else passed++;
    checks++; if ({mul_a, mul_b, out_sum, out_count} !== 56'd0) $display("FAIL reset data: got %h required 0", {mul_a, mul_b, out_sum, out_count}); else passed++;
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready_after: got %b required 1", in_ready); else passed++;
  endtask

  task automatic test_single();
    va = {}; vb = {}; vf = {};
    set_vec(16'h0200, 16'h0300, 1'b0);
    check_vector("single", 0);
    checks++; if (start_hi !== 4) $display("FAIL single start_cycles: got %0d required 4", start_hi); else passed++;
    checks++; if (out_sum !== 16'h0000) $display("FAIL single cleared: got %h required 0000", out_sum); else passed++;
  endtask

  task automatic test_three();
    va = {}; vb = {}; vf = {};
    set_vec(16'h0100, 16'h0200, 1'b0);
    set_vec(16'h0080, 16'h0400, 1'b0);
    set_vec(16'hFF00, 16'h0100, 1'b0);
    check_vector("three", 1);
  endtask

  task automatic test_saturation();
    va = {}; vb = {}; vf = {};
    set_vec(16'h7000, 16'h0100, 1'b0);
    set_vec(16'h2000, 16'h0100, 1'b0);
    check_vector("pos_sat", 0);
    va = {}; vb = {}; vf = {};
    set_vec(16'h0100, 16'h0100, 1'b0);
    check_vector("after_sat", 0);
    va = {}; vb = {}; vf = {};
    set_vec(16'h9000, 16'h0100, 1'b0);
    set_vec(16'hE000, 16'h0100, 1'b0);
    check_vector("neg_sat", 0);
    va = {}; vb = {}; vf = {};
    set_vec(16'h7000, 16'h0100, 1'b0);
    set_vec(16'h2000, 16'h0100, 1'b0);
    set_vec(16'hC000, 16'h0100, 1'b0);
    check_vector("sat_recover", 0);
    va = {}; vb = {}; vf = {};
    set_vec(16'h0100, 16'h0100, 1'b1);
    check_vector("mul_ovf", 0);
  endtask

  task automatic test_backpressure();
    logic [15:0] es; logic eo; logic [7:0] ec; bit ok, rok;
    int bad;
    va = {}; vb = {}; vf = {};
    set_vec(16'h0180, 16'hFE00, 1'b0);
    model_expect(es, eo, ec);
    run_vector(0, ok);
    wait_result(rok);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== es || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || !rok) $display("FAIL backpressure stable: %0d bad cycles, last sum %h valid %b, required sum %h valid 1", bad, out_sum, out_valid, es); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL backpressure accept: got %b required 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok; int t;
    push_pair(16'h0100, 16'h0100, 1'b0, 1'b0, ok);
    push_pair(16'h0200, 16'h0100, 1'b1, 1'b0, ok);
    t = 0;
    while (!mul_start && t < 100) begin @(negedge clk); t++; end
    while (mul_start && t < 100) begin @(negedge clk); t++; end
    checks++; if (t >= 100 || !ok) $display("FAIL reset_mid reach_wait: cycles %0d required <100", t); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_ready, mul_start, out_valid, out_overflow} !== 4'b0000) $display("FAIL reset_mid flags: got %b required 0000", {in_ready, mul_start, out_valid, out_overflow}); else passed++;
    checks++; if ({mul_a, mul_b, out_sum, out_count} !== 56'd0) $display("FAIL reset_mid data: got %h required 0", {mul_a, mul_b, out_sum, out_count}); else passed++;
    @(negedge clk); rst = 1'b0;
    va = {}; vb = {}; vf = {};
    set_vec(16'h0100, 16'h0300, 1'b0);
    check_vector("after_reset", 0);
  endtask

  task automatic test_random();
    int n;
    for (int v = 0; v < 10; v++) begin
      va = {}; vb = {}; vf = {};
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) set_vec(16'($urandom), 16'($urandom_range(0, 1023)) - 16'd512, 1'b0);
        else set_vec(16'($urandom_range(0, 8191)) - 16'd4096, 16'($urandom_range(0, 2047)) - 16'd1024, $urandom_range(0, 7) == 0);
      end
      check_vector($sformatf("random%0d", v), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
